bus_xfer_ctrl: RTL and testbench

//  Drives the CPU internal bus. Accepts one encoded transfer command (source, destination)

---
 rtl/bus_xfer_pkg.sv | 36 +++
 rtl/onehot_dec5.sv | 11 +
 rtl/bus_xfer_ctrl.sv | 64 ++++++
 tb/tb_bus_xfer_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/bus_xfer_pkg.sv
// bus_xfer_pkg: shared bus codes, sizes and FSM encoding for the bus transfer controller
package bus_xfer_pkg;
  localparam int NUM_SRC = 24;
  localparam int NUM_DST = 24;
  localparam logic [4:0] SRC_R0 = 5'd0;
  localparam logic [4:0] SRC_HI = 5'd16;
  localparam logic [4:0] SRC_LO = 5'd17;
  localparam logic [4:0] SRC_ZHI = 5'd18;
  localparam logic [4:0] SRC_ZLO = 5'd19;
  localparam logic [4:0] SRC_PC = 5'd20;
  localparam logic [4:0] SRC_MDR = 5'd21;
  localparam logic [4:0] SRC_C_SIGN_EXT = 5'd22;
  localparam logic [4:0] SRC_INPORT = 5'd23;
  localparam logic [4:0] DST_R0 = 5'd0;
  localparam logic [4:0] DST_HI = 5'd16;
  localparam logic [4:0] DST_LO = 5'd17;
  localparam logic [4:0] DST_PC = 5'd18;
  localparam logic [4:0] DST_MDR = 5'd19;
  localparam logic [4:0] DST_MAR = 5'd20;
  localparam logic [4:0] DST_IR = 5'd21;
  localparam logic [4:0] DST_Y = 5'd22;
  localparam logic [4:0] DST_OUTPORT = 5'd23;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;
  localparam logic [1:0] ST_ERR = 2'd3;
  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    DRIVE = ST_DRIVE,
    LATCH = ST_LATCH,
    ERR   = ST_ERR
  } state_t;
  function automatic logic code_ok(input logic [4:0] code, input int limit);
    return int'(code) < limit;
  endfunction
endpackage

// File: rtl/onehot_dec5.sv
// onehot_dec5: 5-bit bus code to 24-bit one-hot enable, all-zero for illegal codes
module onehot_dec5
  import bus_xfer_pkg::*;
(
  input  logic [4:0]  code,
  output logic [23:0] oh,
  output logic        legal
);
  assign legal = code_ok(code, NUM_SRC);
  assign oh = legal ? 24'd1 << code : '0;
endmodule

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: sequences one-hot bus drive, settle delay and single-cycle capture
module bus_xfer_ctrl
  import bus_xfer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_src,
  input  logic [4:0]  req_dst,
  output logic [23:0] src_out_oh,
  output logic [23:0] dst_in_oh,
  output logic        busy,
  output logic        done,
  output logic        err
);
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("bus_xfer_ctrl: SETTLE_CYCLES must be in 1..15");
  end
  state_t state, nxt;
  logic [3:0] cnt;
  logic [4:0] src_q, dst_q;
  logic [23:0] src_oh, dst_oh;
  logic src_ok, dst_ok, accept, legal;
  assign accept = req_valid && req_ready;
  assign legal = code_ok(req_src, NUM_SRC) && code_ok(req_dst, NUM_DST);
  onehot_dec5 u_src_dec (.code(src_q), .oh(src_oh), .legal(src_ok));
  onehot_dec5 u_dst_dec (.code(dst_q), .oh(dst_oh), .legal(dst_ok));
  // state, settle counter and codes captured only on a legal accept
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
      cnt <= '0;
      src_q <= '0;
      dst_q <= '0;
    end else begin
      state <= nxt;
      if (accept && legal) begin
        src_q <= req_src;
        dst_q <= req_dst;
        cnt <= 4'(SETTLE_CYCLES);
      end else if (state == DRIVE) begin
        cnt <= cnt - 4'd1;
      end
    end
  end
  // next-state: DRIVE lasts exactly SETTLE_CYCLES, LATCH and ERR last one cycle
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = accept ? (legal ? DRIVE : ERR) : IDLE;
      DRIVE: nxt = (cnt == 4'd1) ? LATCH : DRIVE;
      default: nxt = IDLE;
    endcase
  end
  assign req_ready = state == IDLE;
  assign busy = state == DRIVE || state == LATCH;
  assign done = state == LATCH;
  assign err = state == ERR;
  assign src_out_oh = (busy && src_ok) ? src_oh : '0;
  assign dst_in_oh = (done && dst_ok) ? dst_oh : '0;
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb_bus_xfer_ctrl: directed checks of bus_xfer_ctrl with settle periods of 1 and 3
module tb_bus_xfer_ctrl;
  logic clock = 1'b0;
  logic clear_n = 1'b0;
  logic [4:0] req_src = '0, req_dst = '0;
  logic valid_a = 1'b0, valid_b = 1'b0;
  logic ready_a, busy_a, done_a, err_a;
  logic ready_b, busy_b, done_b, err_b;
  logic [23:0] src_a, dst_a, src_b, dst_b;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  bus_xfer_ctrl #(.SETTLE_CYCLES(1)) u_a (
    .clock(clock), .clear_n(clear_n), .req_valid(valid_a), .req_ready(ready_a),
    .req_src(req_src), .req_dst(req_dst), .src_out_oh(src_a), .dst_in_oh(dst_a),
    .busy(busy_a), .done(done_a), .err(err_a)
  );

  bus_xfer_ctrl #(.SETTLE_CYCLES(3)) u_b (
    .clock(clock), .clear_n(clear_n), .req_valid(valid_b), .req_ready(ready_b),
    .req_src(req_src), .req_dst(req_dst), .src_out_oh(src_b), .dst_in_oh(dst_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [23:0] oh(input int i);
    logic [23:0] one = 24'd1;
    return one << i;
  endfunction

  // enables never multi-hot, err and done never together
  always @(negedge clock) begin
    chk("onehot0", {31'd0, $onehot0(src_a) && $onehot0(dst_a) && $onehot0(src_b) && $onehot0(dst_b)}, 32'd1);
    chk("err_done_excl", {30'd0, err_a && done_a, err_b && done_b}, 32'd0);
  end

  initial begin
    #2;
    chk("rst_a", {src_a, 4'd0, ready_a, busy_a, done_a, err_a}, {24'd0, 4'd0, 4'b1000});
    chk("rst_dst_a", {8'd0, dst_a}, 32'd0);
    chk("rst_b", {src_b, 4'd0, ready_b, busy_b, done_b, err_b}, {24'd0, 4'd0, 4'b1000});
    #20 clear_n = 1'b1;
    tick;

    // basic transfer, settle 1
    req_src = 5'd5; req_dst = 5'd12; valid_a = 1'b1;
    tick; valid_a = 1'b0;
    chk("t1_drive_src", {8'd0, src_a}, 32'h20);
    chk("t1_drive_dst", {8'd0, dst_a}, 32'h0);
    chk("t1_drive_flags", {28'd0, ready_a, busy_a, done_a, err_a}, 32'b0100);
    tick;
    chk("t1_latch_src", {8'd0, src_a}, 32'h20);
    chk("t1_latch_dst", {8'd0, dst_a}, 32'h1000);
    chk("t1_latch_flags", {28'd0, ready_a, busy_a, done_a, err_a}, 32'b0110);
    tick;
    chk("t1_idle_src", {8'd0, src_a}, 32'h0);
    chk("t1_idle_flags", {28'd0, ready_a, busy_a, done_a, err_a}, 32'b1000);

    // settle 3, MDR -> IR
    req_src = 5'd21; req_dst = 5'd21; valid_b = 1'b1;
    tick; valid_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_src", {8'd0, src_b}, {8'd0, oh(21)});
      chk("t2_dst", {8'd0, dst_b}, (i == 3) ? {8'd0, oh(21)} : 32'd0);
      chk("t2_flags", {28'd0, ready_b, busy_b, done_b, err_b}, (i == 3) ? 32'b0110 : 32'b0100);
      tick;
    end
    chk("t2_end", {src_b, 4'd0, ready_b, busy_b, done_b, err_b}, {24'd0, 4'd0, 4'b1000});

    // illegal source, then illegal destination, then a legal request
    req_src = 5'd26; req_dst = 5'd2; valid_a = 1'b1;
    tick; valid_a = 1'b0;
    chk("t3_err_src", {src_a, 4'd0, ready_a, busy_a, done_a, err_a}, {24'd0, 4'd0, 4'b0001});
    chk("t3_err_dst_oh", {8'd0, dst_a}, 32'd0);
    tick;
    chk("t3_err_clear", {28'd0, ready_a, busy_a, done_a, err_a}, 32'b1000);
    req_src = 5'd3; req_dst = 5'd31; valid_a = 1'b1;
    tick; valid_a = 1'b0;
    chk("t3_err_dst", {src_a, 4'd0, ready_a, busy_a, done_a, err_a}, {24'd0, 4'd0, 4'b0001});
    tick;
    req_src = 5'd0; req_dst = 5'd23; valid_a = 1'b1;
    tick; valid_a = 1'b0;
    chk("t3_after_src", {8'd0, src_a}, 32'h1);
    tick;
    chk("t3_after_dst", {8'd0, dst_a}, 32'h800000);
    tick;

    // valid held with codes changing every cycle: accepts at cycles 0, 5, 10
    valid_b = 1'b1;
    for (int k = 0; k < 15; k++) begin
      req_src = 5'(k); req_dst = 5'(23 - k);
      tick;
      chk("t4_src", {8'd0, src_b}, (k % 5 == 4) ? 32'd0 : {8'd0, oh(k - k % 5)});
      chk("t4_dst", {8'd0, dst_b}, (k % 5 == 3) ? {8'd0, oh(23 - (k - k % 5))} : 32'd0);
      chk("t4_ready_done", {30'd0, ready_b, done_b}, (k % 5 == 4) ? 32'b10 : (k % 5 == 3) ? 32'b01 : 32'b00);
    end
    valid_b = 1'b0;
    tick;

    // reset mid-DRIVE aborts the capture
    req_src = 5'd20; req_dst = 5'd4; valid_b = 1'b1;
    tick; valid_b = 1'b0;
    chk("t5_drive", {8'd0, src_b}, {8'd0, oh(20)});
    tick; tick;
    #2 clear_n = 1'b0;
    #1;
    chk("t5_abort", {src_b, 4'd0, ready_b, busy_b, done_b, err_b}, {24'd0, 4'd0, 4'b1000});
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t5_no_capture", {7'd0, done_b, dst_b}, 32'd0);
    end
    clear_n = 1'b1;
    tick;
    chk("t5_release", {src_b, 4'd0, ready_b, busy_b, done_b, err_b}, {24'd0, 4'd0, 4'b1000});

    // full legal sweep, settle 1
    for (int s = 0; s < 24; s++) begin
      for (int d = 0; d < 24; d++) begin
        req_src = 5'(s); req_dst = 5'(d); valid_a = 1'b1;
        tick; valid_a = 1'b0;
        chk("t6_src", {8'd0, src_a}, {8'd0, oh(s)});
        tick;
        chk("t6_dst", {8'd0, dst_a}, {8'd0, oh(d)});
        tick;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
